// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//   Word-addressed data memory behind the load/store queue. Serves one load at
//   a time with a fixed READ_LATENCY, returning the word with a one-cycle valid
//   pulse. Retired stores write a full word in a single cycle and are never
//   blocked.
//
// Optional feature (compile-time macro): DMEM_WRITE_BYPASS_EN
//   Defined   : a write to the latched index on the response-forming edge is
//               forwarded into mem_rdata (new data).
//   Undefined : the array is read before that write lands (old data).
//
// Ports
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   flush            cancels a pending read; clears mem_rdata
//   mem_rd_en        load request (ignored while mem_busy)
//   mem_raddr        load byte address, bits [1:0] ignored
//   mem_rdata        registered word result
//   mem_rdata_valid  one-cycle pulse qualifying mem_rdata
//   mem_busy         a read is in flight (state != IDLE)
//   mem_write_en     retired-store write strobe
//   mem_waddr        store byte address, bits [1:0] ignored
//   mem_wdata        store word
//   rd_overrun       sticky: a request arrived while busy and was dropped
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  mem_rd_en,
  input  logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_rdata_valid,
  output logic                  mem_busy,
  input  logic                  mem_write_en,
  input  logic [ADDR_WIDTH-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  rd_overrun
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 4;

`ifdef DMEM_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_lat_check
    $error("data_mem_ctrl: READ_LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE_S,
    BUSY_S,
    RESP_S
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   valid_q;
  logic                   overrun_q;
  logic                   load_rsp;

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

  logic [IDX_W-1:0]       ridx, widx, rsp_idx;
  logic [DATA_WIDTH-1:0]  rsp_word;

  // Addresses wrap modulo DEPTH: only the word-index bits are used.
  assign ridx = mem_raddr[IDX_W+1:2];
  assign widx = mem_waddr[IDX_W+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_raddr[1:0], mem_raddr[ADDR_WIDTH-1:IDX_W+2],
                              mem_waddr[1:0], mem_waddr[ADDR_WIDTH-1:IDX_W+2]};

  // With READ_LATENCY==1 the response is formed on the request edge itself,
  // so the index comes straight from the request port.
  assign rsp_idx = (state_q == IDLE_S) ? ridx : idx_q;

  // The array read sees pre-edge contents. A same-edge write is forwarded only
  // when bypass is enabled, or in the single-cycle case where the request and
  // the write arrive together in IDLE (the write is defined to land first).
  always_comb begin
    rsp_word = mem_q[rsp_idx];
    if (mem_write_en && (widx == rsp_idx) &&
        (BYPASS || (READ_LATENCY == 1 && state_q == IDLE_S))) begin
      rsp_word = mem_wdata;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    load_rsp = 1'b0;
    unique case (state_q)
      IDLE_S: begin
        if (mem_rd_en) begin
          idx_d = ridx;
          if (READ_LATENCY == 1) begin
            state_d  = RESP_S;
            load_rsp = 1'b1;
          end else begin
            cnt_d   = CNT_W'(READ_LATENCY - 1);
            state_d = BUSY_S;
          end
        end
      end
      BUSY_S: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d  = RESP_S;
          load_rsp = 1'b1;
        end
      end
      RESP_S:  state_d = IDLE_S;
      default: state_d = IDLE_S;
    endcase
    // Flush overrides everything: no acceptance, no response, back to IDLE.
    if (flush) begin
      state_d  = IDLE_S;
      cnt_d    = '0;
      load_rsp = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE_S;
      cnt_q     <= '0;
      idx_q     <= '0;
      rdata_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      valid_q <= load_rsp;
      if (flush) begin
        rdata_q <= '0;
      end else if (load_rsp) begin
        rdata_q <= rsp_word;
      end
      if (mem_rd_en && (state_q != IDLE_S)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset; resetting it would turn the RAM
  // into a huge flop bank. Contents are X until written.
  always_ff @(posedge clk) begin
    if (mem_write_en) begin
      mem_q[widx] <= mem_wdata;
    end
  end

  assign mem_rdata       = rdata_q;
  assign mem_rdata_valid = valid_q;
  assign mem_busy        = (state_q != IDLE_S);
  assign rd_overrun      = overrun_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
//   Scoreboard bench: stimulus pushes expected read words into a queue, a
//   negedge monitor pops and compares whenever a DUT raises mem_rdata_valid.
//   dut0 uses READ_LATENCY=2, dut1 uses READ_LATENCY=1.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;

  logic        flush0, rd_en0, we0;
  logic [31:0] raddr0, waddr0, wdata0;
  logic [31:0] rdata0;
  logic        valid0, busy0, ovr0;

  logic        rd_en1, we1;
  logic [31:0] raddr1, waddr1, wdata1;
  logic [31:0] rdata1;
  logic        valid1, busy1, ovr1;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  always #5 clk = ~clk;

  data_mem_ctrl #(.READ_LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0),
    .mem_rd_en(rd_en0), .mem_raddr(raddr0),
    .mem_rdata(rdata0), .mem_rdata_valid(valid0), .mem_busy(busy0),
    .mem_write_en(we0), .mem_waddr(waddr0), .mem_wdata(wdata0),
    .rd_overrun(ovr0)
  );

  data_mem_ctrl #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .mem_rd_en(rd_en1), .mem_raddr(raddr1),
    .mem_rdata(rdata1), .mem_rdata_valid(valid1), .mem_busy(busy1),
    .mem_write_en(we1), .mem_waddr(waddr1), .mem_wdata(wdata1),
    .rd_overrun(ovr1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (valid0) begin
      if (exp_q0.size() == 0) check("dut0_unexpected_valid", 32'd1, 32'd0);
      else check("dut0_rdata", rdata0, exp_q0.pop_front());
    end
    if (valid1) begin
      if (exp_q1.size() == 0) check("dut1_unexpected_valid", 32'd1, 32'd0);
      else check("dut1_rdata", rdata1, exp_q1.pop_front());
    end
  end

  task automatic wr0(input logic [31:0] a, input logic [31:0] d);
    we0 = 1'b1; waddr0 = a; wdata0 = d;
    tick();
    we0 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    flush0 = 1'b0; rd_en0 = 1'b0; we0 = 1'b0; raddr0 = '0; waddr0 = '0; wdata0 = '0;
    rd_en1 = 1'b0; we1 = 1'b0; raddr1 = '0; waddr1 = '0; wdata1 = '0;
    repeat (2) tick();
    check("rst_rdata", rdata0, 32'h0);
    check("rst_valid", {31'd0, valid0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_overrun", {31'd0, ovr0}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: basic read latency 2, sub-word address bits ignored
    wr0(32'h10, 32'hDEADBEEF);
    rd_en0 = 1'b1; raddr0 = 32'h12; exp_q0.push_back(32'hDEADBEEF);
    tick();
    rd_en0 = 1'b0;
    check("t1_busy_T1", {31'd0, busy0}, 32'd1);
    check("t1_valid_T1", {31'd0, valid0}, 32'd0);
    tick();
    check("t1_busy_T2", {31'd0, busy0}, 32'd1);
    check("t1_valid_T2", {31'd0, valid0}, 32'd1);
    tick();
    check("t1_busy_T3", {31'd0, busy0}, 32'd0);
    check("t1_valid_T3", {31'd0, valid0}, 32'd0);
    check("t1_overrun", {31'd0, ovr0}, 32'd0);

    // 3: flush cancels a pending read
    wr0(32'h20, 32'h1);
    rd_en0 = 1'b1; raddr0 = 32'h20;
    tick();
    rd_en0 = 1'b0; flush0 = 1'b1;
    tick();
    flush0 = 1'b0;
    check("t3_busy", {31'd0, busy0}, 32'd0);
    check("t3_valid", {31'd0, valid0}, 32'd0);
    check("t3_rdata", rdata0, 32'h0);
    tick();
    rd_en0 = 1'b1; raddr0 = 32'h20; exp_q0.push_back(32'h1);
    tick();
    rd_en0 = 1'b0;
    repeat (3) tick();

    // 4: write on the response-forming edge, same index
    wr0(32'h30, 32'hA);
    rd_en0 = 1'b1; raddr0 = 32'h30;
    tick();
    rd_en0 = 1'b0;
    we0 = 1'b1; waddr0 = 32'h30; wdata0 = 32'hB;
`ifdef DMEM_WRITE_BYPASS_EN
    exp_q0.push_back(32'hB);
`else
    exp_q0.push_back(32'hA);
`endif
    tick();
    we0 = 1'b0;
    check("t4_valid", {31'd0, valid0}, 32'd1);
    tick();
    rd_en0 = 1'b1; raddr0 = 32'h30; exp_q0.push_back(32'hB);
    tick();
    rd_en0 = 1'b0;
    repeat (3) tick();

    // 5: address wrap, write during busy still commits
    wr0(32'h0, 32'h55);
    rd_en0 = 1'b1; raddr0 = 32'h1000; exp_q0.push_back(32'h55);
    tick();
    rd_en0 = 1'b0;
    wr0(32'h40, 32'h77);
    repeat (2) tick();
    rd_en0 = 1'b1; raddr0 = 32'h40; exp_q0.push_back(32'h77);
    tick();
    rd_en0 = 1'b0;
    repeat (3) tick();

    // Simultaneous write and read of the same index in IDLE: new data
    we0 = 1'b1; waddr0 = 32'h50; wdata0 = 32'h99;
    rd_en0 = 1'b1; raddr0 = 32'h50; exp_q0.push_back(32'h99);
    tick();
    we0 = 1'b0; rd_en0 = 1'b0;
    repeat (3) tick();

    // Overrun: request while busy is dropped and sets the sticky flag
    rd_en0 = 1'b1; raddr0 = 32'h50; exp_q0.push_back(32'h99);
    tick();
    raddr0 = 32'h10;
    tick();
    rd_en0 = 1'b0;
    check("ovr_set", {31'd0, ovr0}, 32'd1);
    repeat (3) tick();
    check("ovr_sticky", {31'd0, ovr0}, 32'd1);

    // 6: reset while busy
    rd_en0 = 1'b1; raddr0 = 32'h40;
    tick();
    rd_en0 = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_busy", {31'd0, busy0}, 32'd0);
    check("t6_valid", {31'd0, valid0}, 32'd0);
    check("t6_rdata", rdata0, 32'h0);
    check("t6_overrun", {31'd0, ovr0}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("t6_post_busy", {31'd0, busy0}, 32'd0);
    rd_en0 = 1'b1; raddr0 = 32'h40; exp_q0.push_back(32'h77);
    tick();
    rd_en0 = 1'b0;
    repeat (3) tick();

    // 2: READ_LATENCY=1 on dut1, back-to-back request in the valid cycle
    we1 = 1'b1; waddr1 = 32'h10; wdata1 = 32'h12345678;
    tick();
    we1 = 1'b0;
    rd_en1 = 1'b1; raddr1 = 32'h10; exp_q1.push_back(32'h12345678);
    tick();
    check("t2_valid", {31'd0, valid1}, 32'd1);
    check("t2_busy", {31'd0, busy1}, 32'd1);
    raddr1 = 32'h14;
    tick();
    rd_en1 = 1'b0;
    check("t2_overrun", {31'd0, ovr1}, 32'd1);
    check("t2_busy_after", {31'd0, busy1}, 32'd0);
    check("t2_valid_after", {31'd0, valid1}, 32'd0);
    rd_en1 = 1'b1; raddr1 = 32'h10; exp_q1.push_back(32'h12345678);
    tick();
    rd_en1 = 1'b0;
    repeat (4) tick();

    check("drain_q0", exp_q0.size(), 32'd0);
    check("drain_q1", exp_q1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
